// File: rtl/sta_tile_scheduler_pkg.sv
// sta_pkg: shared types and constant helpers for the systolic tile scheduler.
// Holds the FSM state enum, lane skew and run-length functions, int typedefs.
package sta_pkg;

    typedef logic signed [7:0]  int8_t;
    typedef logic signed [31:0] int32_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OUT  = 2'd2
    } sta_state_e;

    // Lane delay, in cycles, caused by pipeline registers every tile rows/cols.
    function automatic int lane_skew(input int idx, input int tile);
        return idx / tile;
    endfunction

    // Cycles from first RUN cycle until the far corner PE holds its final sum.
    function automatic int run_len(input int k, input int n, input int tile,
                                   input int rd_lat, input int pe_lat);
        return k + 2 * ((n - 1) / tile) + rd_lat + pe_lat;
    endfunction

endpackage

// File: rtl/sta_tile_scheduler_lane_window.sv
// sta_lane_window: read window for one operand lane (enable + beat index).
// Ports: i_run, i_cnt, i_skew, i_k in; o_en, o_idx out.
module sta_lane_window #(
    parameter int CW = 9,
    parameter int KW = 9,
    parameter int IW = 8
) (
    input  logic          i_run,
    input  logic [CW-1:0] i_cnt,
    input  logic [CW-1:0] i_skew,
    input  logic [KW-1:0] i_k,
    output logic          o_en,
    output logic [IW-1:0] o_idx
);

    localparam int WW = ((CW > KW) ? CW : KW) + 1;

    logic [WW-1:0] w_cnt;
    logic [WW-1:0] w_skew;
    logic [WW-1:0] w_k;
    logic [WW-1:0] w_diff;

    assign w_cnt  = WW'(i_cnt);
    assign w_skew = WW'(i_skew);
    assign w_k    = WW'(i_k);
    assign w_diff = w_cnt - w_skew;

    assign o_en  = i_run & (w_cnt >= w_skew) & (w_diff < w_k);
    assign o_idx = o_en ? w_diff[IW-1:0] : '0;

endmodule

// File: rtl/sta_tile_scheduler.sv
// sta_tile_scheduler: sequences one NxN systolic tile (skewed reads, load_sum,
// result handshake). Ports: clk, reset (async active-low), start, k_steps,
// ready, a/b_rd_en, a/b_rd_idx, load_sum, c_valid, c_ready, busy, done.
// Macro STA_TILE_SCHEDULER_PERF_EN adds perf_run_cycles / perf_stall_cycles.
module sta_tile_scheduler
    import sta_pkg::*;
#(
    parameter int N            = 8,
    parameter int TILE_SIZE    = 2,
    parameter int VECTOR_WIDTH = 4,
    parameter int MAX_K        = 256,
    parameter int RD_LAT       = 1,
    parameter int PE_LAT       = 1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic [$clog2(MAX_K+1)-1:0]           k_steps,
    output logic                                 ready,
    output logic [N-1:0]                         a_rd_en,
    output logic [N-1:0][$clog2(MAX_K)-1:0]      a_rd_idx,
    output logic [N-1:0]                         b_rd_en,
    output logic [N-1:0][$clog2(MAX_K)-1:0]      b_rd_idx,
    output logic [N-1:0][N-1:0]                  load_sum,
    output logic                                 c_valid,
    input  logic                                 c_ready,
    output logic                                 busy,
    output logic                                 done
`ifdef STA_TILE_SCHEDULER_PERF_EN
    ,
    output logic [31:0]                          perf_run_cycles,
    output logic [31:0]                          perf_stall_cycles
`endif
);

    localparam int KW = $clog2(MAX_K + 1);
    localparam int IW = $clog2(MAX_K);
    localparam int CW = $clog2(MAX_K + 2 * N + RD_LAT + PE_LAT);

    if (VECTOR_WIDTH < 1 || TILE_SIZE < 1) begin : g_bad_cfg
        $error("sta_tile_scheduler: VECTOR_WIDTH and TILE_SIZE must be >= 1");
    end

    sta_state_e    r_state;
    logic [CW-1:0] r_cnt;
    logic [KW-1:0] r_k;

    logic          w_run;
    logic          w_out;
    logic [CW-1:0] w_len;
    logic          w_last;

    assign w_run  = (r_state == RUN);
    assign w_out  = (r_state == OUT);
    assign w_len  = CW'(run_len(int'(r_k), N, TILE_SIZE, RD_LAT, PE_LAT));
    assign w_last = (r_cnt == w_len - 1'b1);

    assign ready   = (r_state == IDLE);
    assign busy    = ~ready;
    assign c_valid = w_out;
    assign done    = w_out & c_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_k     <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (start && (k_steps != '0)) begin
                        r_state <= RUN;
                        r_cnt   <= '0;
                        r_k     <= k_steps;
                    end
                end
                RUN: begin
                    if (w_last) begin
                        r_state <= OUT;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                OUT: begin
                    if (c_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        sta_lane_window #(.CW(CW), .KW(KW), .IW(IW)) u_a (
            .i_run  (w_run),
            .i_cnt  (r_cnt),
            .i_skew (CW'(lane_skew(i, TILE_SIZE))),
            .i_k    (r_k),
            .o_en   (a_rd_en[i]),
            .o_idx  (a_rd_idx[i])
        );
        sta_lane_window #(.CW(CW), .KW(KW), .IW(IW)) u_b (
            .i_run  (w_run),
            .i_cnt  (r_cnt),
            .i_skew (CW'(lane_skew(i, TILE_SIZE))),
            .i_k    (r_k),
            .o_en   (b_rd_en[i]),
            .o_idx  (b_rd_idx[i])
        );
    end

    // Beat 0 reaches PE(r,c) after the read latency plus both edge skews.
    for (genvar r = 0; r < N; r++) begin : g_row
        for (genvar c = 0; c < N; c++) begin : g_col
            assign load_sum[r][c] = w_run & (r_cnt == CW'(RD_LAT
                + lane_skew(c, TILE_SIZE) + lane_skew(r, TILE_SIZE)));
        end
    end

`ifdef STA_TILE_SCHEDULER_PERF_EN
    logic [31:0] r_perf_run;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_perf_run   <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_run && (r_perf_run != '1)) begin
                r_perf_run <= r_perf_run + 1'b1;
            end
            if (w_out && !c_ready && (r_perf_stall != '1)) begin
                r_perf_stall <= r_perf_stall + 1'b1;
            end
        end
    end

    assign perf_run_cycles   = r_perf_run;
    assign perf_stall_cycles = r_perf_stall;
`endif

endmodule
